// File: rtl/and_result_serial_tx_pkg.sv
// rtl/and_result_serial_tx_pkg.sv - FSM encoding and counter-width helper for the AND serial transmitter
package and_result_serial_tx_pkg;

  // Same numeric encoding the serial receiver side decodes.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/and_result_serial_tx_bit_timer.sv
// rtl/and_result_serial_tx_bit_timer.sv - bit-period timer; tick marks the last clk of each frame bit
module bit_timer
  import and_result_serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/and_result_serial_tx.sv
// rtl/and_result_serial_tx.sv - latches op_a & op_b and sends it as a start/data/stop serial frame
module and_result_serial_tx
  import and_result_serial_tx_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int LSB_FIRST    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int BW = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick, accept, out_bit;
  logic [WIDTH-1:0] shifted;

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid & in_ready;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // The outgoing bit always sits at one end of the shift register.
  if (LSB_FIRST != 0) begin : g_lsb
    assign out_bit = shreg_q[0];
    assign shifted = shreg_q >> 1;
  end else begin : g_msb
    assign out_bit = shreg_q[WIDTH-1];
    assign shifted = shreg_q << 1;
  end

  // Held clear while idle so the start bit gets a full period from the accept edge.
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (in_ready),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d = op_a & op_b;
          state_d = ST_START;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          tx_d    = out_bit;
          shreg_d = shifted;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q == LAST_BIT) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + BW'(1);
            tx_d    = out_bit;
            shreg_d = shifted;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_and_result_serial_tx.sv
// tb/tb_and_result_serial_tx.sv - scoreboard bench for two transmitter configurations
module tb_and_result_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid_w [2];
  logic       in_ready_w [2];
  logic       tx_w       [2];
  logic       busy_w     [2];
  logic       done_w     [2];
  logic [7:0] a_w        [2];
  logic [7:0] b_w        [2];

  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  logic [7:0] q_res0[$], q_res1[$];
  int         q_acc0[$], q_acc1[$];

  bit         in_frame  [2];
  int         frames    [2];
  logic [7:0] last_rx   [2];
  logic [7:0] prev_rx   [2];
  int         last_done [2];
  int         prev_done [2];

  and_result_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .LSB_FIRST(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w[0]), .in_ready(in_ready_w[0]),
    .op_a(a_w[0]), .op_b(b_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  and_result_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .LSB_FIRST(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w[1]), .in_ready(in_ready_w[1]),
    .op_a(a_w[1]), .op_b(b_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input bit ok, input string nm, input longint act, input longint req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
  endfunction

  function automatic void push(input int k, input logic [7:0] r, input int acc);
    if (k == 0) begin q_res0.push_back(r); q_acc0.push_back(acc); end
    else        begin q_res1.push_back(r); q_acc1.push_back(acc); end
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q_res0.size() : q_res1.size();
  endfunction

  function automatic bit pop(input int k, output logic [7:0] r, output int acc);
    r = 8'h00; acc = 0;
    if (qsize(k) == 0) return 1'b0;
    if (k == 0) begin r = q_res0.pop_front(); acc = q_acc0.pop_front(); end
    else        begin r = q_res1.pop_front(); acc = q_acc1.pop_front(); end
    return 1'b1;
  endfunction

  // Line levels of a whole frame in transmit order: start, data, stop.
  function automatic logic [9:0] exp_frame(input logic [7:0] res, input bit lsb);
    logic [9:0] f;
    f[0] = 1'b0;
    f[9] = 1'b1;
    for (int i = 0; i < 8; i++) f[i+1] = lsb ? res[i] : res[7-i];
    return f;
  endfunction

  task automatic rec(input int k);
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && in_valid_w[k] && in_ready_w[k]) push(k, a_w[k] & b_w[k], cyc + 1);
    end
  endtask

  task automatic mon(input int k);
    int cpb, ea;
    bit lsb, have, stable, aborted;
    logic [9:0] fb;
    logic [7:0] er, rx;
    cpb = (k == 0) ? 4 : 1;
    lsb = (k == 0);
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (tx_w[k] !== 1'b0) begin
        chk(done_w[k] === 1'b0, "idle_done_low", done_w[k], 0);
        continue;
      end
      in_frame[k] = 1'b1;
      have = pop(k, er, ea);
      chk(have, "expected_available", 0, 1);
      stable = 1'b1;
      aborted = 1'b0;
      fb = '0;
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < cpb; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (!rst_n) aborted = 1'b1;
          if (aborted) break;
          if (c == 0) fb[b] = tx_w[k];
          else if (tx_w[k] !== fb[b]) stable = 1'b0;
          if (done_w[k] !== 1'b0 || busy_w[k] !== 1'b1 || in_ready_w[k] !== 1'b0) stable = 1'b0;
        end
        if (aborted) break;
      end
      if (aborted) begin in_frame[k] = 1'b0; continue; end
      @(negedge clk);
      if (!rst_n) begin in_frame[k] = 1'b0; continue; end
      for (int i = 0; i < 8; i++) rx[i] = lsb ? fb[i+1] : fb[8-i];
      chk(fb === exp_frame(er, lsb), "frame_bits", fb, exp_frame(er, lsb));
      chk(stable, "bit_hold_busy", 0, 1);
      chk(done_w[k] === 1'b1, "done_pulse", done_w[k], 1);
      chk(tx_w[k] === 1'b1, "done_cycle_idle_high", tx_w[k], 1);
      chk(busy_w[k] === 1'b0, "busy_clear", busy_w[k], 0);
      chk(cyc - ea == 10 * cpb, "done_latency", cyc - ea, 10 * cpb);
      prev_rx[k]   = last_rx[k];
      last_rx[k]   = rx;
      prev_done[k] = last_done[k];
      last_done[k] = cyc;
      frames[k]++;
      in_frame[k] = 1'b0;
    end
  endtask

  task automatic send(input int k, input logic [7:0] a, input logic [7:0] b);
    bit got;
    got = 1'b0;
    @(negedge clk);
    a_w[k] = a;
    b_w[k] = b;
    in_valid_w[k] = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      #2;
      got = in_ready_w[k] && rst_n;
      @(negedge clk);
    end
    if (!got) chk(1'b0, "accept_timeout", 0, 1);
  endtask

  task automatic wait_quiet(input int k);
    bit q;
    q = 1'b0;
    for (int i = 0; i < 1000 && !q; i++) begin
      @(negedge clk);
      #3;
      q = !busy_w[k] && !in_frame[k] && (qsize(k) == 0);
    end
    if (!q) chk(1'b0, "quiet_timeout", 0, 1);
  endtask

  initial rec(0);
  initial rec(1);
  initial mon(0);
  initial mon(1);

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int f0;
    logic [7:0] ra, rb;
    for (int k = 0; k < 2; k++) begin
      in_frame[k] = 0; frames[k] = 0; last_done[k] = 0; prev_done[k] = 0;
      last_rx[k] = 8'h00; prev_rx[k] = 8'h00;
    end

    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid_w[k] = 1'b1;
      a_w[k] = 8'($urandom);
      b_w[k] = 8'($urandom);
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk(tx_w[k] === 1'b1, "reset_tx", tx_w[k], 1);
      chk(busy_w[k] === 1'b0, "reset_busy", busy_w[k], 0);
      chk(done_w[k] === 1'b0, "reset_done", done_w[k], 0);
      chk(in_ready_w[k] === 1'b1, "reset_in_ready", in_ready_w[k], 1);
      in_valid_w[k] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame: F0 & 3C.
    f0 = frames[0];
    send(0, 8'hF0, 8'h3C);
    in_valid_w[0] = 1'b0;
    wait_quiet(0);
    chk(frames[0] == f0 + 1, "basic_frame_count", frames[0] - f0, 1);
    chk(last_rx[0] === 8'h30, "basic_result", last_rx[0], 8'h30);

    // Inputs wiggled mid-frame must not disturb the latched result.
    f0 = frames[0];
    ra = 8'($urandom);
    rb = 8'($urandom);
    send(0, ra, rb);
    in_valid_w[0] = 1'b0;
    repeat (12) @(negedge clk);
    a_w[0] = ~ra;
    b_w[0] = 8'($urandom);
    in_valid_w[0] = 1'b1;
    #2;
    chk(in_ready_w[0] === 1'b0, "busy_in_ready", in_ready_w[0], 0);
    repeat (3) @(negedge clk);
    in_valid_w[0] = 1'b0;
    wait_quiet(0);
    chk(frames[0] == f0 + 1, "busy_single_done", frames[0] - f0, 1);
    chk(last_rx[0] === (ra & rb), "busy_result", last_rx[0], ra & rb);

    // Back-to-back with in_valid held high.
    f0 = frames[0];
    send(0, 8'hFF, 8'hA5);
    send(0, 8'h0F, 8'hFF);
    in_valid_w[0] = 1'b0;
    wait_quiet(0);
    chk(frames[0] == f0 + 2, "b2b_frames", frames[0] - f0, 2);
    chk(prev_rx[0] === 8'hA5, "b2b_first", prev_rx[0], 8'hA5);
    chk(last_rx[0] === 8'h0F, "b2b_second", last_rx[0], 8'h0F);
    chk(last_done[0] - prev_done[0] == 41, "b2b_done_gap", last_done[0] - prev_done[0], 41);

    // Reset during data bit 3 (a zero bit of F7).
    f0 = frames[0];
    send(0, 8'hF7, 8'hFF);
    in_valid_w[0] = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    chk(tx_w[0] === 1'b0, "pre_reset_tx_low", tx_w[0], 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk(tx_w[0] === 1'b1, "async_reset_tx", tx_w[0], 1);
    chk(busy_w[0] === 1'b0, "async_reset_busy", busy_w[0], 0);
    chk(in_ready_w[0] === 1'b1, "async_reset_in_ready", in_ready_w[0], 1);
    chk(done_w[0] === 1'b0, "async_reset_done", done_w[0], 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    chk(frames[0] == f0, "no_done_after_abort", frames[0] - f0, 0);
    ra = 8'($urandom);
    rb = 8'($urandom);
    send(0, ra, rb);
    in_valid_w[0] = 1'b0;
    wait_quiet(0);
    chk(frames[0] == f0 + 1, "post_reset_frame", frames[0] - f0, 1);
    chk(last_rx[0] === (ra & rb), "post_reset_result", last_rx[0], ra & rb);

    // One clock per bit, MSB first.
    f0 = frames[1];
    send(1, 8'h81, 8'hC1);
    in_valid_w[1] = 1'b0;
    wait_quiet(1);
    chk(frames[1] == f0 + 1, "cpb1_frame", frames[1] - f0, 1);
    chk(last_rx[1] === 8'h81, "cpb1_result", last_rx[1], 8'h81);

    // Randomized traffic: gaps, held valid and mid-frame noise on both instances.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 14; i++) begin
        send(k, 8'($urandom), 8'($urandom));
        if ($urandom_range(0, 2) == 0) continue;
        in_valid_w[k] = 1'b0;
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(1, 5)) @(negedge clk);
          a_w[k] = 8'($urandom);
          b_w[k] = 8'($urandom);
          in_valid_w[k] = 1'b1;
          @(negedge clk);
          in_valid_w[k] = 1'b0;
        end
        repeat ($urandom_range(0, 50)) @(negedge clk);
      end
      in_valid_w[k] = 1'b0;
      wait_quiet(k);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
